// File: rtl/mem_model_hs.sv
// Cycle-accurate word memory behind valid/ready request and response channels.
// One request in flight; programmable access latency, byte enables and error flagging.
module mem_model_hs #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFS   = $clog2(BE_W);
  localparam int IDX   = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((64'd1 << OFS) - 64'd1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;

  logic              mem_we;
  logic              addr_err;
  logic [IDX-1:0]    word_idx;

  logic [DATA_W-1:0] mem_data [0:DEPTH-1];

  // Decode always works from the latched address so late req_* changes cannot leak in.
  assign word_idx = IDX'(addr_q >> OFS);
  assign addr_err = ((addr_q & OFS_MASK) != '0) || ((addr_q >> (IDX + OFS)) != '0);

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          err_d   = addr_err;
          mem_we  = write_q && !addr_err;
          rdata_d = (write_q || addr_err) ? '0 : mem_data[word_idx];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request payload is only consumed in BUSY, which is unreachable without a fresh capture.
  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_q[b]) mem_data[word_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_model_hs.sv
// Scoreboard bench for mem_model_hs: a 32-bit/LATENCY=2 instance and a 64-bit/LATENCY=1 instance.
module tb_mem_model_hs;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_be;

  logic        r64_req_valid, r64_req_ready, r64_req_write, r64_resp_valid, r64_resp_ready, r64_resp_err;
  logic [31:0] r64_req_addr;
  logic [63:0] r64_req_wdata, r64_resp_rdata;
  logic [7:0]  r64_req_be;

  int checks = 0;
  int errors = 0;

  logic [32:0] q32 [$];
  logic [64:0] q64 [$];
  logic [32:0] m32_exp;
  logic [64:0] m64_exp;

  mem_model_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_model_hs #(.DATA_W(64), .ADDR_W(32), .DEPTH(256), .LATENCY(1)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(r64_req_valid), .req_ready(r64_req_ready), .req_write(r64_req_write),
    .req_addr(r64_req_addr), .req_wdata(r64_req_wdata), .req_be(r64_req_be),
    .resp_valid(r64_resp_valid), .resp_ready(r64_resp_ready),
    .resp_rdata(r64_resp_rdata), .resp_err(r64_resp_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: one pop-and-compare per response handshake.
  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL resp32_unexpected actual=%h/%b required=none", resp_rdata, resp_err);
      end else begin
        m32_exp = q32.pop_front();
        if ({resp_err, resp_rdata} !== m32_exp) begin
          errors++;
          $display("FAIL resp32 actual err=%b rdata=%h required err=%b rdata=%h",
                   resp_err, resp_rdata, m32_exp[32], m32_exp[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (r64_resp_valid && r64_resp_ready) begin
      checks++;
      if (q64.size() == 0) begin
        errors++;
        $display("FAIL resp64_unexpected actual=%h/%b required=none", r64_resp_rdata, r64_resp_err);
      end else begin
        m64_exp = q64.pop_front();
        if ({r64_resp_err, r64_resp_rdata} !== m64_exp) begin
          errors++;
          $display("FAIL resp64 actual err=%b rdata=%h required err=%b rdata=%h",
                   r64_resp_err, r64_resp_rdata, m64_exp[64], m64_exp[63:0]);
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] er, input logic ee, input bit push);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_be = be;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("accept32_timeout", 64'(req_ready), 64'd1);
    @(posedge clk);
    if (push) q32.push_back({ee, er});
    #1;
    req_valid = 1'b0; req_write = ~wr; req_addr = a ^ 32'h4; req_wdata = ~wd; req_be = ~be;
  endtask

  // Edges from acceptance until resp_valid is seen; call right after issue returns.
  task automatic edges_to_valid(output int k);
    k = 0;
    @(negedge clk);
    while (!resp_valid && k < 50) begin @(posedge clk); k++; @(negedge clk); end
  endtask

  task automatic wait_resp(input string name);
    int k;
    edges_to_valid(k);
    chk({name, "_latency"}, 64'(k), 64'd2);
    @(negedge clk);
    chk({name, "_valid_clear"}, 64'(resp_valid), 64'd0);
    chk({name, "_ready_back"}, 64'(req_ready), 64'd1);
  endtask

  task automatic txn(input string name, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input logic [31:0] er, input logic ee);
    issue(wr, a, wd, be, er, ee, 1'b1);
    wait_resp(name);
  endtask

  task automatic txn64(input string name, input logic wr, input logic [31:0] a,
                       input logic [63:0] wd, input logic [7:0] be, input logic [63:0] er);
    int k;
    @(posedge clk); #1;
    r64_req_valid = 1'b1; r64_req_write = wr; r64_req_addr = a; r64_req_wdata = wd; r64_req_be = be;
    @(negedge clk);
    chk({name, "_ready"}, 64'(r64_req_ready), 64'd1);
    @(posedge clk);
    q64.push_back({1'b0, er});
    #1;
    r64_req_valid = 1'b0; r64_req_wdata = ~wd; r64_req_addr = a ^ 32'h8;
    k = 0;
    @(negedge clk);
    while (!r64_resp_valid && k < 50) begin @(posedge clk); k++; @(negedge clk); end
    chk({name, "_latency"}, 64'(k), 64'd1);
    @(negedge clk);
    chk({name, "_valid_clear"}, 64'(r64_resp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    resp_ready = 1'b1;
    r64_req_valid = 1'b0; r64_req_write = 1'b0; r64_req_addr = '0; r64_req_wdata = '0; r64_req_be = '0;
    r64_resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Preload and read back word 50
    txn("wr_c8", 1'b1, 32'hC8, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    txn("rd_c8", 1'b0, 32'hC8, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Byte-enable merge on word 51
    txn("wr_cc_full", 1'b1, 32'hCC, 32'h11223344, 4'hF, 32'h0, 1'b0);
    txn("wr_cc_be",   1'b1, 32'hCC, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    txn("rd_cc",      1'b0, 32'hCC, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

    // Error cases, then word 0 must be intact
    txn("wr_0",      1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0);
    txn("rd_misal",  1'b0, 32'hC9, 32'h0, 4'h0, 32'h0, 1'b1);
    txn("wr_oor",    1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    txn("rd_0",      1'b0, 32'h0, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0);

    // Zero byte-enable write is a normal no-op
    txn("wr_cc_be0", 1'b1, 32'hCC, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    txn("rd_cc2",    1'b0, 32'hCC, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

    // Back-pressure with a second request waiting
    resp_ready = 1'b0;
    issue(1'b0, 32'hC8, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hCC; req_wdata = 32'h0; req_be = 4'h0;
    edges_to_valid(k);
    chk("bp_latency", 64'(k), 64'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_rdata", 64'(resp_rdata), 64'hDEADBEEF);
      chk("bp_err", 64'(resp_err), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_req_ready_hs", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("bp_ready_after_hs", 64'(req_ready), 64'd1);
    chk("bp_valid_after_hs", 64'(resp_valid), 64'd0);
    @(posedge clk);
    q32.push_back({1'b0, 32'h11BB33DD});
    #1;
    req_valid = 1'b0;
    wait_resp("bp_second");

    // Reset while a write to word 52 is in flight
    txn("wr_d0_zero", 1'b1, 32'hD0, 32'h0, 4'hF, 32'h0, 1'b0);
    txn("rd_c8_pre",  1'b0, 32'hC8, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 32'hD0, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("midrst_resp_err", 64'(resp_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    txn("rd_d0", 1'b0, 32'hD0, 32'h0, 4'h0, 32'h0, 1'b0);

    // 64-bit, 256-word, single-cycle latency instance
    txn64("w64_full", 1'b1, 32'h40, 64'h0123456789ABCDEF, 8'hFF, 64'h0);
    txn64("r64_full", 1'b0, 32'h40, 64'h0, 8'h00, 64'h0123456789ABCDEF);
    txn64("w64_low",  1'b1, 32'h40, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'h0);
    txn64("r64_low",  1'b0, 32'h40, 64'h0, 8'h00, 64'h01234567FFFFFFFF);

    repeat (3) @(negedge clk);
    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q64_drained", 64'(q64.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
